// File: rtl/wb_stage_if.sv
// Bundle of MEM-stage handshake, data-cache response and register-file write
// port signals seen by the writeback stage.
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_pc;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic        mem_is_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rt_old;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_pc;
  logic        wb_stall;

  modport master (
    output mem_valid, mem_pc, mem_wen, mem_waddr, mem_result, mem_is_load,
           mem_load_type, mem_addr_lo, mem_rt_old, dresp_valid, dresp_data, flush,
    input  mem_ready, rf_we, rf_waddr, rf_wdata, wb_pc, wb_stall
  );

  modport slave (
    input  mem_valid, mem_pc, mem_wen, mem_waddr, mem_result, mem_is_load,
           mem_load_type, mem_addr_lo, mem_rt_old, dresp_valid, dresp_data, flush,
    output mem_ready, rf_we, rf_waddr, rf_wdata, wb_pc, wb_stall
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: accepts one instruction from MEM, commits ALU results the
// next cycle, holds loads until the data-cache response arrives, extends or
// merges the loaded data, then drives the register-file write port.
module wb_stage #(
  parameter bit ENABLE_LWLR = 1'b1
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;

  logic        ld_wen;
  logic [4:0]  ld_waddr;
  logic [2:0]  ld_type;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rt_old;
  logic [31:0] ld_pc;

  logic        accept;
  logic        commit;
  logic        commit_we;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_data;
  logic [31:0] commit_pc;
  logic [31:0] load_data;

  function automatic logic [31:0] extend(input logic [2:0]  ltype,
                                         input logic [1:0]  a,
                                         input logic [31:0] d,
                                         input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (ltype)
      3'd1: r = {{24{b[7]}}, b};
      3'd2: r = {24'h0, b};
      3'd3: r = {{16{h[15]}}, h};
      3'd4: r = {16'h0, h};
      3'd5: begin
        if (ENABLE_LWLR) begin
          case (a)
            2'd0:    r = {d[7:0],  rt[23:0]};
            2'd1:    r = {d[15:0], rt[15:0]};
            2'd2:    r = {d[23:0], rt[7:0]};
            default: r = d;
          endcase
        end else begin
          r = d;
        end
      end
      3'd6: begin
        if (ENABLE_LWLR) begin
          case (a)
            2'd0:    r = d;
            2'd1:    r = {rt[31:24], d[31:8]};
            2'd2:    r = {rt[31:16], d[31:16]};
            default: r = {rt[31:8],  d[31:24]};
          endcase
        end else begin
          r = d;
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Shape the raw response word according to the held load's type.
  always_comb begin
    load_data = extend(ld_type, ld_addr_lo, bus.dresp_data, ld_rt_old);
  end

  // Next state and the commit request for the following cycle.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    commit       = 1'b0;
    commit_we    = 1'b0;
    commit_waddr = ld_waddr;
    commit_data  = load_data;
    commit_pc    = ld_pc;
    case (state)
      IDLE: begin
        // flush kills whatever MEM presents this cycle, so nothing commits next cycle
        accept = bus.mem_valid && !bus.flush;
        if (accept) begin
          if (bus.mem_is_load) begin
            state_next = WAIT;
          end else begin
            commit       = 1'b1;
            commit_we    = bus.mem_wen && (bus.mem_waddr != '0);
            commit_waddr = bus.mem_waddr;
            commit_data  = bus.mem_result;
            commit_pc    = bus.mem_pc;
          end
        end
      end
      WAIT: begin
        if (bus.dresp_valid) begin
          state_next = IDLE;
          if (!bus.flush) begin
            commit    = 1'b1;
            commit_we = ld_wen && (ld_waddr != '0);
          end
        end else if (bus.flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.dresp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_ready = (state == IDLE);
  assign bus.wb_stall  = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the load's context while its response is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_wen     <= 1'b0;
      ld_waddr   <= '0;
      ld_type    <= '0;
      ld_addr_lo <= '0;
      ld_rt_old  <= '0;
      ld_pc      <= '0;
    end else if (accept && bus.mem_is_load) begin
      ld_wen     <= bus.mem_wen;
      ld_waddr   <= bus.mem_waddr;
      ld_type    <= bus.mem_load_type;
      ld_addr_lo <= bus.mem_addr_lo;
      ld_rt_old  <= bus.mem_rt_old;
      ld_pc      <= bus.mem_pc;
    end
  end

  // Registered register-file write port; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.wb_pc    <= '0;
    end else begin
      bus.rf_we <= commit_we;
      if (commit_we) begin
        bus.rf_waddr <= commit_waddr;
        bus.rf_wdata <= commit_data;
      end
      if (commit) begin
        bus.wb_pc <= commit_pc;
      end
    end
  end

  // A response with no load outstanding points at a cache-side protocol bug.
  a_no_idle_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.dresp_valid && (state == IDLE)))
    else $warning("wb_stage: dresp_valid received while idle, ignored");

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected register-file writes are queued
// when instructions are accepted and matched against every rf_we pulse.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_stage_if bus();

  wb_stage #(.ENABLE_LWLR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } wr_t;

  wr_t         sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference extension, written straight from the load-type table.
  function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [1:0] a,
                                          input logic [31:0] d, input logic [31:0] rt);
    logic [31:0] sh;
    sh = d >> (8 * a);
    case (t)
      3'd1: return {{24{sh[7]}}, sh[7:0]};
      3'd2: return {24'h0, sh[7:0]};
      3'd3: return a[1] ? {{16{d[31]}}, d[31:16]} : {{16{d[15]}}, d[15:0]};
      3'd4: return a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
      3'd5: case (a)
              2'd0: return {d[7:0], rt[23:0]};
              2'd1: return {d[15:0], rt[15:0]};
              2'd2: return {d[23:0], rt[7:0]};
              default: return d;
            endcase
      3'd6: case (a)
              2'd0: return d;
              2'd1: return {rt[31:24], d[31:8]};
              2'd2: return {rt[31:16], d[31:16]};
              default: return {rt[31:8], d[31:24]};
            endcase
      default: return d;
    endcase
  endfunction

  // Every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(bus.rf_we), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(bus.rf_waddr), 32'(e.waddr));
        check("wr_data", bus.rf_wdata, e.wdata);
        check("wr_pc", bus.wb_pc, e.pc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.mem_valid     = 1'b0;
    bus.mem_pc        = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_waddr     = '0;
    bus.mem_result    = '0;
    bus.mem_is_load   = 1'b0;
    bus.mem_load_type = '0;
    bus.mem_addr_lo   = '0;
    bus.mem_rt_old    = '0;
    bus.dresp_valid   = 1'b0;
    bus.dresp_data    = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},    32'(bus.rf_we), 32'd0);
    check({tag, "_waddr"}, 32'(bus.rf_waddr), 32'd0);
    check({tag, "_wdata"}, bus.rf_wdata, 32'd0);
    check({tag, "_pc"},    bus.wb_pc, 32'd0);
    check({tag, "_ready"}, 32'(bus.mem_ready), 32'd1);
    check({tag, "_stall"}, 32'(bus.wb_stall), 32'd0);
  endtask

  // One-cycle non-load handshake; leaves mem_valid high for back-to-back use.
  task automatic drive_alu(input logic wen, input logic [4:0] waddr,
                           input logic [31:0] result, input logic [31:0] pc);
    wr_t e;
    bus.mem_valid   = 1'b1;
    bus.mem_is_load = 1'b0;
    bus.mem_wen     = wen;
    bus.mem_waddr   = waddr;
    bus.mem_result  = result;
    bus.mem_pc      = pc;
    check("alu_ready", 32'(bus.mem_ready), 32'd1);
    if (wen && waddr != 5'd0) begin
      e.waddr = waddr; e.wdata = result; e.pc = pc;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic present_load(input logic [2:0] t, input logic [1:0] a, input logic [4:0] waddr,
                              input logic [31:0] rt, input logic [31:0] pc);
    bus.mem_valid     = 1'b1;
    bus.mem_is_load   = 1'b1;
    bus.mem_wen       = 1'b1;
    bus.mem_waddr     = waddr;
    bus.mem_load_type = t;
    bus.mem_addr_lo   = a;
    bus.mem_rt_old    = rt;
    bus.mem_pc        = pc;
  endtask

  // Full load: accept, wait lat cycles, return data; returns in the commit cycle.
  task automatic do_load(input logic [2:0] t, input logic [1:0] a, input logic [4:0] waddr,
                         input logic [31:0] rt, input logic [31:0] pc,
                         input logic [31:0] data, input int unsigned lat);
    wr_t e;
    present_load(t, a, waddr, rt, pc);
    check("load_ready", 32'(bus.mem_ready), 32'd1);
    if (waddr != 5'd0) begin
      e.waddr = waddr; e.wdata = ref_ext(t, a, data, rt); e.pc = pc;
      sb.push_back(e);
    end
    tick();
    bus.mem_valid   = 1'b0;
    bus.mem_is_load = 1'b0;
    for (int unsigned i = 1; i < lat; i++) begin
      check("wait_stall", 32'(bus.wb_stall), 32'd1);
      check("wait_ready", 32'(bus.mem_ready), 32'd0);
      tick();
    end
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = data;
    tick();
    bus.dresp_valid = 1'b0;
    bus.dresp_data  = $urandom;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Back-to-back non-loads.
    drive_alu(1'b1, 5'd3, 32'h11, 32'h100);
    check("b2b_first_we", 32'(bus.rf_we), 32'd1);
    drive_alu(1'b1, 5'd4, 32'h22, 32'h104);
    check("b2b_second_addr", 32'(bus.rf_waddr), 32'd4);
    idle_in();
    tick();
    check("b2b_we_ends", 32'(bus.rf_we), 32'd0);
    check("b2b_hold_data", bus.rf_wdata, 32'h22);

    // LB with 3-cycle response latency.
    do_load(3'd1, 2'd2, 5'd5, 32'h0, 32'h200, 32'h1280FF00, 3);
    check("lb_we", 32'(bus.rf_we), 32'd1);
    check("lb_addr", 32'(bus.rf_waddr), 32'd5);
    check("lb_data", bus.rf_wdata, 32'hFFFFFF80);
    tick();
    check("lb_we_pulse", 32'(bus.rf_we), 32'd0);

    // Every load type at every byte offset.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 4; a++) begin
        do_load(3'(t), 2'(a), 5'(1 + (t * 4 + a) % 31), 32'h11223344, 32'(32'h300 + t * 16 + a * 4),
                32'hAABBCCDD, $urandom_range(1, 3));
        if (t == 5 && a == 1) check("lwl_a1", bus.rf_wdata, 32'hCCDD3344);
        if (t == 6 && a == 2) check("lwr_a2", bus.rf_wdata, 32'h1122AABB);
        if (t == 4 && a == 2) check("lhu_a2", bus.rf_wdata, 32'h0000AABB);
        if (t == 2 && a == 3) check("lbu_a3", bus.rf_wdata, 32'h000000AA);
      end
    end
    idle_in();

    // Destination r0 and wen=0 never write.
    drive_alu(1'b1, 5'd0, 32'hDEAD, 32'h400);
    idle_in();
    check("r0_no_we", 32'(bus.rf_we), 32'd0);
    drive_alu(1'b0, 5'd9, 32'hBEEF, 32'h404);
    idle_in();
    check("wen0_no_we", 32'(bus.rf_we), 32'd0);

    // Flush one cycle after a load is accepted; response discarded in DRAIN.
    present_load(3'd0, 2'd0, 5'd7, 32'h0, 32'h500);
    tick();
    idle_in();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("drain_ready", 32'(bus.mem_ready), 32'd0);
    check("drain_stall", 32'(bus.wb_stall), 32'd1);
    tick();
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = 32'h12345678;
    check("drain_hold", 32'(bus.mem_ready), 32'd0);
    tick();
    bus.dresp_valid = 1'b0;
    check("drain_exit_ready", 32'(bus.mem_ready), 32'd1);
    check("drain_no_we", 32'(bus.rf_we), 32'd0);

    // Flush coinciding with the response in WAIT.
    present_load(3'd0, 2'd0, 5'd8, 32'h0, 32'h600);
    tick();
    idle_in();
    bus.flush       = 1'b1;
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = 32'hCAFEF00D;
    tick();
    idle_in();
    check("flush_resp_ready", 32'(bus.mem_ready), 32'd1);
    check("flush_resp_no_we", 32'(bus.rf_we), 32'd0);

    // Flush in IDLE kills the presented instruction.
    bus.mem_valid  = 1'b1;
    bus.mem_wen    = 1'b1;
    bus.mem_waddr  = 5'd10;
    bus.mem_result = 32'h55;
    bus.flush      = 1'b1;
    tick();
    idle_in();
    check("idle_flush_no_we", 32'(bus.rf_we), 32'd0);
    check("idle_flush_ready", 32'(bus.mem_ready), 32'd1);

    // Random mix of non-loads and loads.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        drive_alu(1'($urandom), 5'($urandom), $urandom, 32'(32'h1000 + i * 4));
        idle_in();
      end else begin
        do_load(3'($urandom), 2'($urandom), 5'($urandom_range(1, 31)), $urandom,
                32'(32'h1000 + i * 4), $urandom, $urandom_range(1, 4));
      end
    end
    idle_in();
    tick();

    // Reset in the middle of WAIT, then a stray response.
    present_load(3'd0, 2'd0, 5'd12, 32'h0, 32'h700);
    tick();
    idle_in();
    tick();
    check("pre_rst_stall", 32'(bus.wb_stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    tick();
    bus.dresp_valid = 1'b1;
    bus.dresp_data  = 32'h99999999;
    tick();
    bus.dresp_valid = 1'b0;
    check("stray_no_we", 32'(bus.rf_we), 32'd0);
    check("stray_ready", 32'(bus.mem_ready), 32'd1);
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage; sits directly upstream of the general-purpose register file and drives its write port (we/waddr/wdata).
- Accepts one instruction per handshake from the MEM stage and holds it.
- For loads, waits for the variable-latency data-cache response, applies byte/half/LWL/LWR extension and merging, then commits.
- Non-loads commit their ALU result directly.

Parameters:
ENABLE_LWLR, 1, 1 = implement LWL/LWR merge; 0 = load types 5/6 treated as LW

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_valid  in  1  MEM stage presents an instruction
mem_ready  out  1  wb_stage can accept this cycle
mem_pc  in  32  instruction PC (debug)
mem_wen  in  1  instruction writes a GPR
mem_waddr  in  5  destination register
mem_result  in  32  ALU/link result for non-loads
mem_is_load  in  1  instruction is a load
mem_load_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 as LW
mem_addr_lo  in  2  effective address bits [1:0]
mem_rt_old  in  32  old rt value for LWL/LWR merge
dresp_valid  in  1  load data returned (single-cycle pulse)
dresp_data  in  32  raw aligned word, little-endian
flush  in  1  kill held instruction (exception/eret)
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data
wb_pc  out  32  PC of committing instruction (debug)
wb_stall  out  1  high in WAIT or DRAIN

Behaviour:
- Reset: state IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, wb_pc=0, wb_stall=0, mem_ready=1. All rf_* outputs are registered.
- States:
  - IDLE: empty, or committing the last accepted instruction.
  - WAIT: a load is held and its response is pending.
  - DRAIN: a flushed load's response is pending and will be discarded.
- mem_ready = (state==IDLE). Accept occurs when mem_valid && mem_ready.
- Accept, non-load: the next cycle presents rf_we = mem_wen && (mem_waddr!=0), rf_waddr, rf_wdata=mem_result, wb_pc. State stays IDLE, so back-to-back instructions commit one per cycle. Latency is 1 cycle.
- Accept, load: latch waddr, wen, type, addr_lo, rt_old, pc. Go to WAIT. rf_we=0 the next cycle.
- WAIT with dresp_valid: the next cycle presents rf_we = wen && waddr!=0 and rf_wdata = extend(dresp_data). Go to IDLE. Latency is 1 cycle after dresp_valid.
- dresp_valid and accept in the same cycle cannot occur, since mem_ready=0 in WAIT.
- rf_we is a one-cycle pulse per committed instruction; otherwise 0. rf_waddr and rf_wdata hold their last values when rf_we=0.
- Extension (b = byte at addr_lo, h = half at addr_lo[1]; misaligned LH/LW is trapped upstream and not checked here):
  - LB: sign-extend b.
  - LBU: zero-extend b.
  - LH: sign-extend h.
  - LHU: zero-extend h.
  - LW: word.
  - LWL by addr_lo:
    - 0: {d[7:0], rt[23:0]}
    - 1: {d[15:0], rt[15:0]}
    - 2: {d[23:0], rt[7:0]}
    - 3: d
  - LWR by addr_lo:
    - 0: d
    - 1: {rt[31:24], d[31:8]}
    - 2: {rt[31:16], d[31:16]}
    - 3: {rt[31:8], d[31:24]}
- flush:
  - In IDLE: suppress any commit scheduled for the next cycle (rf_we=0) and ignore mem_valid this cycle.
  - In WAIT without dresp_valid: go to DRAIN.
  - In WAIT with dresp_valid in the same cycle: discard the data, no write, go to IDLE.
  - In DRAIN: no effect.
- DRAIN: the next dresp_valid is discarded with no write, then go to IDLE.
- dresp_valid in IDLE is ignored; an assertion is flagged in simulation.
- rst mid-operation (WAIT or DRAIN): go to IDLE immediately. Any later dresp_valid is ignored.
- Register-file bypass for same-cycle write/read is handled by the register file, not here.

Test Plan:
- Non-load back-to-back:
  - Stimulus: accept {waddr=3, result=0x11} then {waddr=4, result=0x22} on consecutive cycles.
  - Response: rf_we pulses on the two following cycles with (3, 0x11) then (4, 0x22); mem_ready stays 1.
- Load with 3-cycle latency:
  - Stimulus: LB, addr_lo=2, waddr=5; dresp_data=0x1280FF00 arrives 3 cycles after accept.
  - Response: mem_ready=0 and wb_stall=1 during the wait; one cycle after dresp, rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFF80.
- LBU/LHU/LWL/LWR sweep:
  - Stimulus: data=0xAABBCCDD, rt=0x11223344, all addr_lo values.
  - Response: LWL a=1 gives 0xCCDD3344; LWR a=2 gives 0x1122AABB; LHU a=2 gives 0x0000AABB.
- Destination r0:
  - Stimulus: non-load with wen=1, waddr=0.
  - Response: rf_we stays 0.
- Flush while waiting:
  - Stimulus: load accepted, flush asserted 1 cycle later, dresp_valid 2 cycles after that.
  - Response: state DRAIN; no rf_we; mem_ready returns to 1 the cycle after dresp_valid.
- Reset mid-WAIT:
  - Stimulus: rst asserted during WAIT, then a stray dresp_valid.
  - Response: outputs at reset values; no write; mem_ready=1.
